// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// A hit answers one cycle after the request; a miss raises a refill request to
// the memory controller and waits for its completion pulse.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting fetch requests, answering hits
// MISS  | refill outstanding; ic_flag/ins_addr held until ins_rdy
module icache #(
  parameter int INDEX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_ins,
  output logic        if_rdy,
  output logic        ic_flag,
  output logic [31:0] ins_addr,
  input  logic [31:0] ins,
  input  logic        ins_rdy
);

  localparam int NLINES = 1 << INDEX_W;
  localparam int TAG_W  = 30 - INDEX_W;

  typedef enum logic [0:0] {IDLE = 1'b0, MISS = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NLINES-1:0]   r_valid;
  logic [TAG_W-1:0]    r_tag  [NLINES];
  logic [31:0]         r_data [NLINES];
  logic [INDEX_W-1:0]  r_idx;
  logic [TAG_W-1:0]    r_tag_l;
  logic                r_drop;
  logic                r_if_rdy;
  logic [31:0]         r_if_ins;
  logic                r_ic_flag;
  logic [31:0]         r_ins_addr;

  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic                w_accept;
  logic                w_fill;
  logic                w_if_rdy_nxt;
  logic [31:0]         w_if_ins_nxt;
  logic                w_ic_flag_nxt;
  logic [31:0]         w_ins_addr_nxt;
  logic                w_drop_nxt;
  logic                w_latch;
  logic                w_unused;

  assign w_idx    = if_addr[INDEX_W+1:2];
  assign w_tag    = if_addr[31:INDEX_W+2];
  assign w_unused = &{1'b0, if_addr[1:0]};
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // A request is ignored while the previous response is on the bus.
  assign w_accept = (r_state == IDLE) && if_req && !clear && !r_if_rdy;
  assign w_fill   = (r_state == MISS) && ins_rdy;

  // State register; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst)      r_state <= IDLE;
    else if (rdy) r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_hit) w_state_nxt = MISS;
      MISS:    if (ins_rdy)            w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output/next-value decode for the registered outputs and miss bookkeeping.
  always_comb begin
    w_if_rdy_nxt   = 1'b0;
    w_if_ins_nxt   = r_if_ins;
    w_ic_flag_nxt  = r_ic_flag;
    w_ins_addr_nxt = r_ins_addr;
    w_drop_nxt     = r_drop;
    w_latch        = 1'b0;
    case (r_state)
      IDLE: begin
        w_drop_nxt = 1'b0;
        if (w_accept && w_hit) begin
          w_if_rdy_nxt = 1'b1;
          w_if_ins_nxt = r_data[w_idx];
        end else if (w_accept) begin
          w_ic_flag_nxt  = 1'b1;
          w_ins_addr_nxt = {if_addr[31:2], 2'b00};
          w_latch        = 1'b1;
        end
      end
      MISS: begin
        if (ins_rdy) begin
          w_ic_flag_nxt = 1'b0;
          w_drop_nxt    = 1'b0;
          if (!r_drop && !clear) begin
            w_if_rdy_nxt = 1'b1;
            w_if_ins_nxt = ins;
          end
        end else if (clear) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, valid bits and miss bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_drop     <= 1'b0;
      r_if_rdy   <= 1'b0;
      r_if_ins   <= '0;
      r_ic_flag  <= 1'b0;
      r_ins_addr <= '0;
      r_idx      <= '0;
      r_tag_l    <= '0;
    end else if (rdy) begin
      r_drop     <= w_drop_nxt;
      r_if_rdy   <= w_if_rdy_nxt;
      r_if_ins   <= w_if_ins_nxt;
      r_ic_flag  <= w_ic_flag_nxt;
      r_ins_addr <= w_ins_addr_nxt;
      if (w_latch) begin
        r_idx   <= w_idx;
        r_tag_l <= w_tag;
      end
      if (w_fill) r_valid[r_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset; a refill overwrites the line unconditionally.
  always_ff @(posedge clk) begin
    if (!rst && rdy && w_fill) begin
      r_tag[r_idx]  <= r_tag_l;
      r_data[r_idx] <= ins;
    end
  end

  assign if_rdy   = r_if_rdy;
  assign if_ins   = r_if_ins;
  assign ic_flag  = r_ic_flag;
  assign ins_addr = r_ins_addr;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: inputs change and outputs are sampled 1 ns
// after each rising edge.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, if_req, ins_rdy;
  logic [31:0] if_addr, ins;
  logic [31:0] if_ins, ins_addr;
  logic        if_rdy, ic_flag;

  int n_chk  = 0;
  int n_fail = 0;

  icache #(.INDEX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_ins(if_ins), .if_rdy(if_rdy),
    .ic_flag(ic_flag), .ins_addr(ins_addr), .ins(ins), .ins_rdy(ins_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge and release it.
  task automatic req(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
    step();
    if_req = 1'b0;
  endtask

  // Complete an outstanding refill with data d.
  task automatic fill(input logic [31:0] d);
    ins_rdy = 1'b1; ins = d;
    step();
    ins_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; if_req = 1'b0; ins_rdy = 1'b0;
    if_addr = '0; ins = '0;
    step();
    rst = 1'b0;
    chk("rst_if_rdy", {31'b0, if_rdy}, 32'd0);
    chk("rst_ic_flag", {31'b0, ic_flag}, 32'd0);
    chk("rst_ins_addr", ins_addr, 32'd0);
    chk("rst_if_ins", if_ins, 32'd0);

    // cold miss, completion three cycles after the request is raised
    req(32'h0000_1004);
    chk("cold_flag", {31'b0, ic_flag}, 32'd1);
    chk("cold_addr", ins_addr, 32'h0000_1004);
    chk("cold_no_rdy", {31'b0, if_rdy}, 32'd0);
    step();
    chk("cold_flag_hold", {31'b0, ic_flag}, 32'd1);
    fill(32'h0000_0093);
    chk("cold_rdy", {31'b0, if_rdy}, 32'd1);
    chk("cold_ins", if_ins, 32'h0000_0093);
    chk("cold_flag_drop", {31'b0, ic_flag}, 32'd0);
    step();
    chk("cold_pulse", {31'b0, if_rdy}, 32'd0);
    chk("cold_ins_hold", if_ins, 32'h0000_0093);

    // hit after fill; low address bits ignored
    req(32'h0000_1004);
    chk("hit_rdy", {31'b0, if_rdy}, 32'd1);
    chk("hit_ins", if_ins, 32'h0000_0093);
    chk("hit_flag", {31'b0, ic_flag}, 32'd0);
    // request while if_rdy=1 is ignored
    req(32'h0000_3000);
    chk("ign_rdy", {31'b0, if_rdy}, 32'd0);
    chk("ign_flag", {31'b0, ic_flag}, 32'd0);
    req(32'h0000_1007);
    chk("hit_lowbits", if_ins, 32'h0000_0093);
    chk("hit_lowbits_rdy", {31'b0, if_rdy}, 32'd1);
    step();

    // conflict on index 1
    req(32'h0000_1044);
    chk("conf_flag", {31'b0, ic_flag}, 32'd1);
    chk("conf_addr", ins_addr, 32'h0000_1044);
    fill(32'hAAAA_0001);
    chk("conf_ins", if_ins, 32'hAAAA_0001);
    step();
    req(32'h0000_1004);
    chk("conf_remiss", {31'b0, ic_flag}, 32'd1);
    fill(32'h0000_0093);
    step();

    // unaligned miss address is word-aligned on the refill port
    req(32'h0000_6003);
    chk("align_addr", ins_addr, 32'h0000_6000);
    fill(32'h0000_6666);
    step();

    // clear during miss drops the response but fills the line
    req(32'h0000_2000);
    step();
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_flag_hold", {31'b0, ic_flag}, 32'd1);
    fill(32'h1234_5678);
    chk("clr_no_rdy", {31'b0, if_rdy}, 32'd0);
    chk("clr_flag", {31'b0, ic_flag}, 32'd0);
    step();
    chk("clr_no_rdy2", {31'b0, if_rdy}, 32'd0);
    req(32'h0000_2000);
    chk("clr_hit_rdy", {31'b0, if_rdy}, 32'd1);
    chk("clr_hit_ins", if_ins, 32'h1234_5678);
    step();

    // clear coincident with completion
    req(32'h0000_3008);
    clear = 1'b1; fill(32'h0000_CAFE); clear = 1'b0;
    chk("clrc_no_rdy", {31'b0, if_rdy}, 32'd0);
    chk("clrc_ins_hold", if_ins, 32'h1234_5678);
    req(32'h0000_3008);
    chk("clrc_hit", if_ins, 32'h0000_CAFE);
    step();

    // clear in IDLE kills same-cycle hit and miss
    clear = 1'b1; req(32'h0000_1004);
    chk("clri_hit", {31'b0, if_rdy}, 32'd0);
    req(32'h0000_5000); clear = 1'b0;
    chk("clri_miss", {31'b0, ic_flag}, 32'd0);

    // stall during miss
    req(32'h0000_4000);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_flag", {31'b0, ic_flag}, 32'd1);
      chk("stall_addr", ins_addr, 32'h0000_4000);
      chk("stall_rdy", {31'b0, if_rdy}, 32'd0);
    end
    rdy = 1'b1;
    step();
    chk("stall_resume_flag", {31'b0, ic_flag}, 32'd1);
    fill(32'h0000_4444);
    chk("stall_rdy_out", {31'b0, if_rdy}, 32'd1);
    chk("stall_ins", if_ins, 32'h0000_4444);
    step();

    // reset invalidates lines
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst2_if_ins", if_ins, 32'd0);
    chk("rst2_ins_addr", ins_addr, 32'd0);
    chk("rst2_if_rdy", {31'b0, if_rdy}, 32'd0);
    req(32'h0000_1004);
    chk("rst2_miss", {31'b0, ic_flag}, 32'd1);
    chk("rst2_no_hit", {31'b0, if_rdy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
